// File: rtl/msdf_otf_converter_if.sv
// Stream bundle for msdf_otf_converter: serial signed-digit input and parallel result output.
// Optional MSDF_OTF_OVF_EN adds the dataOutArray_ovf discard flag alongside the result.
// valid/ready: a digit or a word moves on a rising edge where its valid and ready are both 1;
// valid is never withdrawn and its data never changes until that edge, and ready never depends on valid.
interface msdf_otf_converter_if #(
   parameter int OUT_W = 29
);
   logic [2:0]       dataInArray_0;
   logic             pValidArray_0;
   logic             readyArray_0;
   logic [OUT_W-1:0] dataOutArray_0;
   logic             validArray_0;
   logic             nReadyArray_0;
`ifdef MSDF_OTF_OVF_EN
   logic             dataOutArray_ovf;

   modport slave (
      input  dataInArray_0, pValidArray_0, nReadyArray_0,
      output readyArray_0, dataOutArray_0, validArray_0, dataOutArray_ovf
   );
   modport master (
      output dataInArray_0, pValidArray_0, nReadyArray_0,
      input  readyArray_0, dataOutArray_0, validArray_0, dataOutArray_ovf
   );
`else
   modport slave (
      input  dataInArray_0, pValidArray_0, nReadyArray_0,
      output readyArray_0, dataOutArray_0, validArray_0
   );
   modport master (
      output dataInArray_0, pValidArray_0, nReadyArray_0,
      input  readyArray_0, dataOutArray_0, validArray_0
   );
`endif
endinterface

// File: rtl/msdf_otf_converter.sv
// On-the-fly conversion of an MSD-first signed-digit stream into a two's-complement word (Q/QM pair).
// Define MSDF_OTF_OVF_EN to add the sticky discarded-digit flag dataOutArray_ovf.
module msdf_otf_converter #(
   parameter int TARGET_PRECISION = 25,
   parameter int INT_DIGITS       = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   msdf_otf_converter_if.slave  io,
   output logic [1:0]           dbg_state_o
);
   localparam int NUM_DIGITS = TARGET_PRECISION + INT_DIGITS;
   localparam int OUT_W      = NUM_DIGITS + 1;
   localparam int CNT_W      = $clog2(NUM_DIGITS + 1);
   localparam logic [CNT_W-1:0] NUM_C = CNT_W'(NUM_DIGITS);

   typedef enum logic [1:0] {ST_ACC = 2'd0, ST_PAD = 2'd1, ST_OUT = 2'd2} state_e;

   state_e           state_q, state_d;
   logic [OUT_W-1:0] q_q, q_d, qm_q, qm_d;
   logic [OUT_W-1:0] data_q, data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             valid_q, valid_d;
   logic             accept;
   logic             d_pos, d_neg, d_last;

   assign d_last = io.dataInArray_0[2];
   assign d_pos  = io.dataInArray_0[1] & ~io.dataInArray_0[0];
   assign d_neg  = io.dataInArray_0[0] & ~io.dataInArray_0[1];
   assign accept = io.pValidArray_0 && (state_q == ST_ACC);

   assign io.readyArray_0   = (state_q == ST_ACC);
   assign io.dataOutArray_0 = data_q;
   assign io.validArray_0   = valid_q;
   assign dbg_state_o       = state_q;

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      qm_d    = qm_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      valid_d = valid_q;
      unique case (state_q)
         ST_ACC: begin
            if (accept) begin
               // Digits beyond the frame length are dropped so scaling stays fixed.
               if (cnt_q < NUM_C) begin
                  if (d_pos) begin
                     q_d  = {q_q[OUT_W-2:0], 1'b1};
                     qm_d = {q_q[OUT_W-2:0], 1'b0};
                  end else if (d_neg) begin
                     q_d  = {qm_q[OUT_W-2:0], 1'b1};
                     qm_d = {qm_q[OUT_W-2:0], 1'b0};
                  end else begin
                     q_d  = {q_q[OUT_W-2:0], 1'b0};
                     qm_d = {qm_q[OUT_W-2:0], 1'b1};
                  end
                  cnt_d = cnt_q + CNT_W'(1);
               end
               if (d_last) begin
                  if (cnt_d == NUM_C) begin
                     state_d = ST_OUT;
                     data_d  = q_d;
                     valid_d = 1'b1;
                  end else begin
                     state_d = ST_PAD;
                  end
               end
            end
         end
         ST_PAD: begin
            q_d   = {q_q[OUT_W-2:0], 1'b0};
            qm_d  = {qm_q[OUT_W-2:0], 1'b1};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == NUM_C) begin
               state_d = ST_OUT;
               data_d  = q_d;
               valid_d = 1'b1;
            end
         end
         ST_OUT: begin
            if (io.nReadyArray_0) begin
               state_d = ST_ACC;
               valid_d = 1'b0;
               q_d     = '0;
               qm_d    = '1;
               cnt_d   = '0;
            end
         end
         default: state_d = ST_ACC;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_ACC;
         q_q     <= '0;
         qm_q    <= '1;
         cnt_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         qm_q    <= qm_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

`ifdef MSDF_OTF_OVF_EN
   logic ovf_q;
   logic discard;
   logic handshake;

   assign discard   = accept && (cnt_q == NUM_C);
   assign handshake = (state_q == ST_OUT) && io.nReadyArray_0;
   assign io.dataOutArray_ovf = ovf_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (handshake) begin
         ovf_q <= 1'b0;
      end else if (discard) begin
         ovf_q <= 1'b1;
      end
   end
`endif
endmodule
